// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Byte-serializing CPU memory controller for the 8-bit platform
//               memory bus. Takes one 1/2/4-byte load or store and issues it
//               as byte cycles. The bus holds RAM with a one-cycle registered
//               read latency and the UART window at addr[IO_SEL_HI -: 2]==2'b11.
//               Load data is returned zero- or sign-extended.
// Ports       : clk_in, rst_n_in (async, active-low)
//               rdy_in             platform ready (0 = bus paused)
//               req_*              CPU request (valid/ready handshake)
//               resp_valid_out     one-cycle completion pulse
//               resp_rdata_out     extended load data (0 after stores)
//               mem_a_out/mem_dout_out/mem_wr_out/mem_din_in  byte bus
//               io_buffer_full_in  UART TX back-pressure
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int IO_SEL_HI = 17
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_wr_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_signed_in,
  input  logic [31:0]       req_wdata_in,
  output logic              resp_valid_out,
  output logic [31:0]       resp_rdata_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic [7:0]        mem_dout_out,
  output logic              mem_wr_out,
  input  logic [7:0]        mem_din_in,
  input  logic              io_buffer_full_in
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic [2:0]        r_nbytes;

  // Progress tracking
  logic [2:0]        r_issue_idx;   // next byte to put on the bus
  logic [2:0]        r_cap_idx;     // next byte to capture from mem_din_in
  logic              r_inflight;    // a read address is on the bus this cycle
  logic              r_capture;     // read data for that address is on mem_din_in
  logic              r_io_wr_prev;  // an I/O-window write is on the bus this cycle
  logic [31:0]       r_rdata;

  // Registered outputs
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;

  // Combinational helpers
  logic              w_accept;
  logic              w_active;
  logic              w_eff_wr;
  logic [ADDR_W-1:0] w_eff_addr;
  logic [31:0]       w_eff_wdata;
  logic [2:0]        w_eff_n;
  logic [2:0]        w_eff_i;
  logic [ADDR_W-1:0] w_byte_addr;
  logic              w_io_hit;
  logic              w_io_block;
  logic              w_issue;
  logic [31:0]       w_wshift;
  logic [7:0]        w_wr_byte;
  logic              w_last_cap;
  logic              w_resp_fire;
  logic [31:0]       w_rdata_merged;
  logic [31:0]       w_rdata_ext;

  function automatic logic [2:0] size_to_n(input logic [1:0] s);
    case (s)
      2'd0:    size_to_n = 3'd1;
      2'd1:    size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

  assign req_ready_out  = (r_state == ST_IDLE);
  assign resp_valid_out = r_resp_valid;
  assign resp_rdata_out = r_resp_rdata;
  assign mem_a_out      = r_mem_a;
  assign mem_dout_out   = r_mem_dout;
  assign mem_wr_out     = r_mem_wr;

  // --------------------------------------------------------------------------
  // Issue datapath. Because the bus outputs are registered, byte 0 is loaded
  // into the output registers on the accepting edge itself; otherwise every
  // access would lose a cycle. The "effective" transaction therefore comes
  // straight from the request port on that edge and from the latched copy
  // afterwards.
  // --------------------------------------------------------------------------
  always_comb begin
    w_accept    = req_valid_in && (r_state == ST_IDLE);
    w_active    = w_accept || (r_state != ST_IDLE);
    w_eff_wr    = w_accept ? req_wr_in            : (r_state == ST_WRITE);
    w_eff_addr  = w_accept ? req_addr_in          : r_addr;
    w_eff_wdata = w_accept ? req_wdata_in         : r_wdata;
    w_eff_n     = w_accept ? size_to_n(req_size_in) : r_nbytes;
    w_eff_i     = w_accept ? 3'd0                 : r_issue_idx;

    w_byte_addr = w_eff_addr + ADDR_W'(w_eff_i);
    w_io_hit    = (w_byte_addr[IO_SEL_HI -: 2] == 2'b11);

    // UART writes wait while the TX buffer is full, and never go out on two
    // consecutive cycles so the UART sees its full flag update in between.
    w_io_block  = w_eff_wr && w_io_hit && (io_buffer_full_in || r_io_wr_prev);
    w_issue     = w_active && rdy_in && (w_eff_i < w_eff_n) && !w_io_block;

    w_wshift    = w_eff_wdata >> {w_eff_i[1:0], 3'b000};
    w_wr_byte   = w_wshift[7:0];
  end

  // --------------------------------------------------------------------------
  // Capture datapath: merge the arriving byte so the final byte can be
  // extended and returned on the same edge that captures it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_last_cap     = r_capture && (r_cap_idx == (r_nbytes - 3'd1));
    w_rdata_merged = r_rdata;
    case (r_cap_idx[1:0])
      2'd0:    w_rdata_merged[7:0]   = mem_din_in;
      2'd1:    w_rdata_merged[15:8]  = mem_din_in;
      2'd2:    w_rdata_merged[23:16] = mem_din_in;
      default: w_rdata_merged[31:24] = mem_din_in;
    endcase

    case (r_size)
      2'd0:    w_rdata_ext = {{24{r_signed & w_rdata_merged[7]}},  w_rdata_merged[7:0]};
      2'd1:    w_rdata_ext = {{16{r_signed & w_rdata_merged[15]}}, w_rdata_merged[15:0]};
      default: w_rdata_ext = w_rdata_merged;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: next state and response strobe
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_resp_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_in) begin
          w_state_next = req_wr_in ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (w_last_cap) begin
          w_state_next = ST_IDLE;
          w_resp_fire  = 1'b1;
        end
      end
      ST_WRITE: begin
        // All bytes went out on earlier edges; respond one cycle after the last.
        if (r_issue_idx == r_nbytes) begin
          w_state_next = ST_IDLE;
          w_resp_fire  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_addr       <= '0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_wdata      <= 32'd0;
      r_nbytes     <= 3'd0;
      r_issue_idx  <= 3'd0;
      r_cap_idx    <= 3'd0;
      r_inflight   <= 1'b0;
      r_capture    <= 1'b0;
      r_io_wr_prev <= 1'b0;
      r_rdata      <= 32'd0;
      r_mem_a      <= '0;
      r_mem_dout   <= 8'd0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      // Byte issue; the address bus returns to 0 whenever nothing is issued
      // so an I/O location is never left presented (I/O reads have side effects).
      r_issue_idx  <= w_eff_i + {2'b00, w_issue};
      r_mem_a      <= w_issue ? w_byte_addr : '0;
      r_mem_wr     <= w_issue && w_eff_wr;
      r_mem_dout   <= (w_issue && w_eff_wr) ? w_wr_byte : 8'd0;
      r_io_wr_prev <= w_issue && w_eff_wr && w_io_hit;

      // Two-stage read pipeline: address on bus, then data on mem_din_in.
      // The data stage completes regardless of rdy_in.
      r_inflight   <= w_issue && !w_eff_wr;
      r_capture    <= r_inflight;

      if (r_capture) begin
        r_rdata   <= w_rdata_merged;
        r_cap_idx <= r_cap_idx + 3'd1;
      end

      if (w_accept) begin
        r_addr    <= req_addr_in;
        r_size    <= req_size_in;
        r_signed  <= req_signed_in;
        r_wdata   <= req_wdata_in;
        r_nbytes  <= size_to_n(req_size_in);
        r_rdata   <= 32'd0;
        r_cap_idx <= 3'd0;
      end

      r_resp_valid <= w_resp_fire;
      if (w_resp_fire) begin
        r_resp_rdata <= (r_state == ST_READ) ? w_rdata_ext : 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte RAM
//               model (one-cycle registered read) on the memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  localparam int c_max_wait = 20;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_full;

  // RAM model with a preload port driven by the stimulus
  logic [7:0]  ram [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  int n_total;
  int n_pass;

  mem_ctrl #(.ADDR_W(32), .IO_SEL_HI(17)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .rdy_in            (rdy),
    .req_valid_in      (req_valid),
    .req_ready_out     (req_ready),
    .req_wr_in         (req_wr),
    .req_addr_in       (req_addr),
    .req_size_in       (req_size),
    .req_signed_in     (req_signed),
    .req_wdata_in      (req_wdata),
    .resp_valid_out    (resp_valid),
    .resp_rdata_out    (resp_rdata),
    .mem_a_out         (mem_a),
    .mem_dout_out      (mem_dout),
    .mem_wr_out        (mem_wr),
    .mem_din_in        (mem_din),
    .io_buffer_full_in (io_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_wr && (mem_a[17:16] != 2'b11)) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Waits for resp_valid, counting the cycle index from the accept cycle.
  task automatic wait_resp(input int first_cycle, output int lat);
    lat = first_cycle;
    while (!resp_valid && lat < c_max_wait) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_req(1'b0, addr, size, sgn, 32'd0);
    wait_resp(1, lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, resp_rdata, exp);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] pa [0:5];
    logic [7:0]  sb [0:3];
    int          lat;
    logic        seen;

    n_total    = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    rdy        = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = 32'd0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_wdata  = 32'd0;
    io_full    = 1'b0;
    pl_en      = 1'b0;
    pl_addr    = 12'd0;
    pl_data    = 8'd0;

    preload(12'h100, 8'h78);
    preload(12'h101, 8'h56);
    preload(12'h102, 8'h34);
    preload(12'h103, 8'h12);
    preload(12'h200, 8'h80);
    preload(12'h201, 8'hFF);
    preload(12'h10A, 8'h00);
    preload(12'h10B, 8'h00);

    // Reset state
    check("rst_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_v", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_a",  mem_a,               32'd0);
    check("rst_mem_wr", {31'd0, mem_wr},     32'd0);
    check("rst_rdata",  resp_rdata,          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load word: addresses in cycles 1..4, response in cycle 6
    start_req(1'b0, 32'h100, 2'd2, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("lw_addr", mem_a, 32'h100 + 32'(k));
      check("lw_wr",   {31'd0, mem_wr}, 32'd0);
      @(negedge clk);
    end
    wait_resp(5, lat);
    check("lw_latency", 32'(lat), 32'd6);
    check("lw_data", resp_rdata, 32'h12345678);
    @(negedge clk);
    check("lw_pulse", {31'd0, resp_valid}, 32'd0);

    // Signed / unsigned byte and half
    run_load("lb_s",  32'h200, 2'd0, 1'b1, 32'hFFFFFF80, 3);
    run_load("lb_u",  32'h200, 2'd0, 1'b0, 32'h00000080, 3);
    run_load("lh_s",  32'h200, 2'd1, 1'b1, 32'hFFFFFF80, 4);
    run_load("lh_u",  32'h200, 2'd1, 1'b0, 32'h0000FF80, 4);

    // Store word, then back-to-back readback accepted in the response cycle
    sb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    start_req(1'b1, 32'h104, 2'd2, 1'b0, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      check("sw_wr",   {31'd0, mem_wr}, 32'd1);
      check("sw_addr", mem_a, 32'h104 + 32'(k));
      check("sw_dout", {24'd0, mem_dout}, {24'd0, sb[k]});
      @(negedge clk);
    end
    check("sw_resp",  {31'd0, resp_valid}, 32'd1);
    check("sw_rdata", resp_rdata, 32'd0);
    check("sw_ready", {31'd0, req_ready}, 32'd1);
    run_load("sw_rb", 32'h104, 2'd2, 1'b0, 32'hDEADBEEF, 6);

    // UART back-pressure: full for three cycles starting at the accept cycle
    io_full = 1'b1;
    start_req(1'b1, 32'h30000, 2'd0, 1'b0, 32'h00000041);
    check("io_hold1", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    check("io_hold2", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    check("io_hold3", {31'd0, mem_wr}, 32'd0);
    io_full = 1'b0;
    @(negedge clk);
    check("io_wr",   {31'd0, mem_wr}, 32'd1);
    check("io_addr", mem_a, 32'h30000);
    check("io_dout", {24'd0, mem_dout}, 32'h41);
    check("io_early", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("io_resp", {31'd0, resp_valid}, 32'd1);
    check("io_after", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);

    // Pause in cycles 2-3 of a word load
    pa = '{32'h100, 32'h101, 32'h0, 32'h0, 32'h102, 32'h103};
    start_req(1'b0, 32'h100, 2'd2, 1'b0, 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("pz_addr", mem_a, pa[k]);
      if (k == 1) rdy = 1'b0;
      if (k == 3) rdy = 1'b1;
      @(negedge clk);
    end
    wait_resp(7, lat);
    check("pz_latency", 32'(lat), 32'd8);
    check("pz_data", resp_rdata, 32'h12345678);
    @(negedge clk);

    // Reset in the middle of a word store, after byte 1 has been written
    start_req(1'b1, 32'h108, 2'd2, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    check("mr_byte1", {24'd0, mem_dout}, 32'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_wr",    {31'd0, mem_wr},     32'd0);
    check("mr_addr",  mem_a,               32'd0);
    check("mr_dout",  {24'd0, mem_dout},   32'd0);
    check("mr_resp",  {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mr_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | resp_valid;
      @(negedge clk);
    end
    check("mr_no_resp", {31'd0, seen}, 32'd0);
    run_load("mr_rb", 32'h108, 2'd2, 1'b0, 32'h0000F00D, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
